cdb_arbiter: RTL
================

# cdb_arbiter

Common-data-bus arbiter and broadcaster: the consumer end of the execution-unit-to-CDB handshake. It accepts completed results from NUM_EXU execution units (ALU, MUL/DIV, LSU, branch), grants at most one per cycle by round-robin, and drives a single registered CDB broadcast to the reservation stations, register file/RAT and ROB. Each unit holds its result until granted, so the arbiter never drops or buffers more than one result.

## Interface
Parameters:
- NUM_EXU, 4, number of requesting execution units (≥2; need not be a power of 2)
- TAG_W, 6, physical-register tag width
- ROB_PTR_W (from rv32i_types), ROB index width carried as inst_id

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- exu_req  in  NUM_EXU  per-unit result valid; held high until granted
- exu_tag  in  NUM_EXU×TAG_W  per-unit destination tag
- exu_wdata  in  NUM_EXU×32  per-unit result data
- exu_inst_id  in  NUM_EXU×ROB_PTR_W  per-unit ROB index
- exu_rdy  out  NUM_EXU  per-unit grant; combinational, one-hot or zero
- cdb_vld  out  1  broadcast valid (registered)
- cdb_tag  out  TAG_W  broadcast tag (registered)
- cdb_wdata  out  32  broadcast data (registered)
- cdb_inst_id  out  ROB_PTR_W  broadcast ROB index (registered)

## Operation
- Transfer on unit i occurs when exu_req[i] && exu_rdy[i] in the same cycle.
- exu_rdy is driven only to a requesting unit: exu_rdy[i] implies exu_req[i]; with no request, exu_rdy = 0.
- Round-robin pointer ptr: search starts at unit ptr and increases with wrap (ptr, ptr+1, ..., NUM_EXU-1, 0, ...). The first requesting unit wins.
- After a grant to unit g, ptr <= (g+1) mod NUM_EXU, wrapping at NUM_EXU rather than at 2^width. With no grant, ptr holds.
- On a grant, the CDB register loads the winner's tag, wdata and inst_id, and cdb_vld <= 1.
- With no grant, cdb_vld <= 0. The tag, wdata and inst_id registers hold their last values; consumers must qualify them with cdb_vld.
- The CDB has no backpressure. Every cdb_vld=1 cycle is consumed by all listeners.
- Reset: cdb_vld, cdb_tag, cdb_wdata, cdb_inst_id and ptr all go to 0. exu_rdy is purely combinational, so it is 0 only when no unit is requesting.
- Counter: grant_cnt, 32-bit, counts transfers, is readable hierarchically, and wraps naturally.

## Timing
- Latency: a result granted in cycle N is broadcast (cdb_vld=1) in cycle N+1.
- Throughput is one result per cycle. Back-to-back grants produce a contiguous cdb_vld.
- exu_rdy depends combinationally only on exu_req and ptr. exu_req is a flop output in every unit, so there is no combinational loop even though unit rdy-to-RS paths depend on exu_rdy.
- Single requester: it is granted in the same cycle regardless of ptr.
- All NUM_EXU requesting continuously: each unit is granted exactly once every NUM_EXU cycles. Worst-case wait is NUM_EXU-1 cycles.
- A unit that deasserts and reasserts req gets no priority reset. Only ptr decides.
- Reset asserted mid-stream: the next cycle shows cdb_vld=0 and ptr=0. A grant computed in the reset cycle does not load the CDB register.

## Structure
- rv32i_types: ROB_PTR_W, and a cdb_t struct (vld, tag, wdata, inst_id) shared with the reservation stations, ROB and RAT.
- Sub-module rr_arbiter #(N): inputs req[N] and ptr; outputs a one-hot gnt[N] and the winner index. It is pure combinational logic.
- cdb_arbiter owns ptr, the CDB register, the mux selected by the winner index, and grant_cnt.

## Test plan
- Reset, then exu_req=4'b0000 for 3 cycles: exu_rdy=0 and cdb_vld=0 throughout.
- Unit 2 alone requests with tag=5, wdata=0xDEADBEEF, inst_id=3: exu_rdy=4'b0100 that cycle, then cdb_vld=1 with the same values next cycle; ptr becomes 3.
- ptr=0 and exu_req=4'b1111 held for 8 cycles: grants go 0,1,2,3,0,1,2,3; cdb_vld is high for 8 contiguous cycles; grant_cnt=8.
- ptr=3 and exu_req=4'b0011: unit 0 is granted, then unit 1. This checks wrap with NUM_EXU=3 too (ptr 2 → 0, never 3).
- ALU-style unit held pending while a higher-priority unit wins: the loser's tag and data stay stable, and it is granted the next cycle without a lost or duplicate broadcast. A scoreboard matches every transfer to exactly one cdb_vld.
- Assert rst in the cycle unit 1 is granted: the next cycle shows cdb_vld=0, cdb_tag=0 and ptr=0.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared core types: ROB index width and the CDB broadcast record used by
// the reservation stations, ROB and RAT.
package rv32i_types;

  localparam int ROB_PTR_W = 5;
  localparam int CDB_TAG_W = 6;

  typedef struct packed {
    logic                 vld;
    logic [CDB_TAG_W-1:0] tag;
    logic [31:0]          wdata;
    logic [ROB_PTR_W-1:0] inst_id;
  } cdb_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i,
// wrapping at N (N need not be a power of two).
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          vld_o
);

  logic [PW:0] cand;

  // Walk the search order ptr, ptr+1, ... and keep the first requester.
  always_comb begin
    cand  = '0;
    idx_o = '0;
    vld_o = 1'b0;
    gnt_o = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_i} + (PW+1)'(k);
      if (cand >= (PW+1)'(N)) begin
        cand = cand - (PW+1)'(N);
      end else begin
        cand = cand;
      end
      for (int u = 0; u < N; u++) begin
        if (!vld_o && req_i[u] && (cand == (PW+1)'(u))) begin
          vld_o = 1'b1;
          idx_o = PW'(u);
        end else begin
          vld_o = vld_o;
        end
      end
    end
    for (int u = 0; u < N; u++) begin
      gnt_o[u] = vld_o && (idx_o == PW'(u));
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: grants one execution-unit result per cycle round-robin and
// broadcasts it on a registered common data bus the following cycle.
module cdb_arbiter
  import rv32i_types::*;
#(
  parameter int NUM_EXU = 4,
  parameter int TAG_W   = CDB_TAG_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_EXU-1:0]             exu_req,
  input  logic [NUM_EXU*TAG_W-1:0]       exu_tag,
  input  logic [NUM_EXU*32-1:0]          exu_wdata,
  input  logic [NUM_EXU*ROB_PTR_W-1:0]   exu_inst_id,
  output logic [NUM_EXU-1:0]             exu_rdy,
  output logic                           cdb_vld,
  output logic [TAG_W-1:0]               cdb_tag,
  output logic [31:0]                    cdb_wdata,
  output logic [ROB_PTR_W-1:0]           cdb_inst_id
);

  localparam int PW = (NUM_EXU > 1) ? $clog2(NUM_EXU) : 1;

  logic [PW-1:0]        ptr_q, ptr_d;
  logic [PW-1:0]        win_idx;
  logic                 win_vld;
  logic [31:0]          grant_cnt, grant_cnt_d;
  logic [TAG_W-1:0]     tag_d;
  logic [31:0]          wdata_d;
  logic [ROB_PTR_W-1:0] inst_id_d;

  rr_arbiter #(.N(NUM_EXU), .PW(PW)) u_rr (
    .req_i (exu_req),
    .ptr_i (ptr_q),
    .gnt_o (exu_rdy),
    .idx_o (win_idx),
    .vld_o (win_vld)
  );

  // Winner mux plus next pointer; the pointer wraps at NUM_EXU, not 2^PW.
  always_comb begin
    tag_d       = '0;
    wdata_d     = '0;
    inst_id_d   = '0;
    for (int i = 0; i < NUM_EXU; i++) begin
      if (win_idx == PW'(i)) begin
        tag_d     = exu_tag[i*TAG_W +: TAG_W];
        wdata_d   = exu_wdata[i*32 +: 32];
        inst_id_d = exu_inst_id[i*ROB_PTR_W +: ROB_PTR_W];
      end else begin
        tag_d     = tag_d;
      end
    end
    if (!win_vld) begin
      ptr_d       = ptr_q;
      grant_cnt_d = grant_cnt;
    end else if (win_idx == PW'(NUM_EXU - 1)) begin
      ptr_d       = '0;
      grant_cnt_d = grant_cnt + 32'd1;
    end else begin
      ptr_d       = win_idx + PW'(1);
      grant_cnt_d = grant_cnt + 32'd1;
    end
  end

  // Pointer, counter and broadcast register; payload holds when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      grant_cnt   <= 32'd0;
      cdb_vld     <= 1'b0;
      cdb_tag     <= '0;
      cdb_wdata   <= 32'd0;
      cdb_inst_id <= '0;
    end else begin
      ptr_q       <= ptr_d;
      grant_cnt   <= grant_cnt_d;
      cdb_vld     <= win_vld;
      if (win_vld) begin
        cdb_tag     <= tag_d;
        cdb_wdata   <= wdata_d;
        cdb_inst_id <= inst_id_d;
      end else begin
        cdb_tag     <= cdb_tag;
        cdb_wdata   <= cdb_wdata;
        cdb_inst_id <= cdb_inst_id;
      end
    end
  end

endmodule
